// File: rtl/regfile_ctx_pkg.sv
// Shared constants and types for the register-file context sequencer.
package regfile_ctx_pkg;

  // First t-register (r8) and size of the t-register bank (r8..r15).
  localparam logic [4:0] T_BASE  = 5'd8;
  localparam int         T_COUNT = 8;

  // Link register written by call instructions.
  localparam logic [4:0] RA_REG  = 5'd31;

  // Context engine state: IDLE accepts requests, RESTORE streams a context back.
  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } ctx_state_t;

  // Register-file address of t-register number idx (0 -> r8 ... 7 -> r15).
  function automatic logic [4:0] t_reg_addr(input logic [2:0] idx);
    return T_BASE + {2'b00, idx};
  endfunction

endpackage

// File: rtl/ctx_stack.sv
// LIFO of saved t-register banks. Push captures a whole bank in one cycle;
// the top entry is read one word at a time through an indexed port.
module ctx_stack
  import regfile_ctx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [T_COUNT*DW-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic [2:0]            i_rd_idx,
  output logic [DW-1:0]         o_rd_word,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count
);

  // Entry address width; a single-entry stack still needs one address bit.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word 7 sits in the MSBs and holds r8, matching the packing of i_push_data.
  logic [T_COUNT-1:0][DW-1:0] r_mem [DEPTH];
  logic [CW-1:0]              r_count;
  logic [CW-1:0]              w_top;
  logic [2:0]                 w_word_sel;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == CW'(0));
  assign o_count    = r_count;
  assign w_top      = r_count - CW'(1);
  // Index 0 (r8) lives in the highest packed word.
  assign w_word_sel = 3'(T_COUNT - 1) - i_rd_idx;
  assign o_rd_word  = r_mem[w_top[AW-1:0]][w_word_sel];

  // Storage write; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[r_count[AW-1:0]] <= i_push_data;
    end
  end

  // Occupancy counter: push and pop are never requested in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= CW'(0);
    end else if (i_push && !o_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/reg_ctx_sequencer.sv
// Single owner of the register-file write port. Arbitrates writeback, the
// buffered link-register write and the context-restore engine (WB > link >
// restore), and manages the saved t-register context stack.
module reg_ctx_sequencer
  import regfile_ctx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         WB_RegWrite,
  input  logic [4:0]                   WB_WriteRegister,
  input  logic [DW-1:0]                WB_WriteData,
  input  logic                         LinkWrite,
  input  logic [DW-1:0]                LinkData,
  input  logic [8*DW-1:0]              tRegistersIn,
  input  logic                         CtxSave,
  input  logic                         CtxRestore,
  output logic                         CtxReady,
  output logic                         CtxErr,
  output logic [$clog2(DEPTH+1)-1:0]   CtxDepth,
  output logic                         RegWrite,
  output logic [4:0]                   WriteRegister,
  output logic [DW-1:0]                WriteData
);

  localparam int CW = $clog2(DEPTH + 1);

  ctx_state_t    r_state;
  logic [2:0]    r_idx;
  logic          r_err;
  logic          r_link_valid;
  logic [DW-1:0] r_link_data;

  logic          w_push;
  logic          w_pop;
  logic          w_restore_go;
  logic          w_req_err;
  logic          w_restore_issue;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [DW-1:0] w_rd_word;

  ctx_stack #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .CW    (CW)
  ) u_stack (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_push      (w_push),
    .i_push_data (tRegistersIn),
    .i_pop       (w_pop),
    .i_rd_idx    (r_idx),
    .o_rd_word   (w_rd_word),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Resolve save/restore requests; they are only looked at while idle.
  always_comb begin
    w_push       = 1'b0;
    w_restore_go = 1'b0;
    w_req_err    = 1'b0;
    if (r_state == IDLE) begin
      if (CtxSave && CtxRestore) begin
        w_req_err = 1'b1;
      end else if (CtxSave) begin
        if (w_full) begin
          w_req_err = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end else if (CtxRestore) begin
        if (w_empty) begin
          w_req_err = 1'b1;
        end else begin
          w_restore_go = 1'b1;
        end
      end else begin
        w_push = 1'b0;
      end
    end else begin
      w_push = 1'b0;
    end
  end

  // Write-port arbitration; a fresh LinkWrite supersedes the buffered value.
  always_comb begin
    RegWrite        = 1'b0;
    WriteRegister   = 5'd0;
    WriteData       = '0;
    w_restore_issue = 1'b0;
    if (WB_RegWrite) begin
      RegWrite      = 1'b1;
      WriteRegister = WB_WriteRegister;
      WriteData     = WB_WriteData;
    end else if (r_link_valid || LinkWrite) begin
      RegWrite      = 1'b1;
      WriteRegister = RA_REG;
      WriteData     = LinkWrite ? LinkData : r_link_data;
    end else if (r_state == RESTORE) begin
      RegWrite        = 1'b1;
      WriteRegister   = t_reg_addr(r_idx);
      WriteData       = w_rd_word;
      w_restore_issue = 1'b1;
    end else begin
      RegWrite = 1'b0;
    end
  end

  // The context is popped on the same edge that retires its last word.
  assign w_pop = w_restore_issue && (r_idx == 3'd7);

  // Context engine FSM with registered error pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_req_err;
      case (r_state)
        IDLE: begin
          if (w_restore_go) begin
            r_state <= RESTORE;
            r_idx   <= 3'd0;
          end
        end
        RESTORE: begin
          if (w_restore_issue) begin
            if (r_idx == 3'd7) begin
              r_state <= IDLE;
              r_idx   <= 3'd0;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

  // Link buffer: holds a link write only while WB owns the port; both target
  // r31 so the newest value simply overwrites an older pending one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
    end else if (WB_RegWrite) begin
      if (LinkWrite) begin
        r_link_valid <= 1'b1;
        r_link_data  <= LinkData;
      end
    end else begin
      r_link_valid <= 1'b0;
    end
  end

  assign CtxReady = (r_state == IDLE);
  assign CtxErr   = r_err;
  assign CtxDepth = w_count;

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Self-checking bench for reg_ctx_sequencer: a queue-based behavioural model
// is compared every cycle, and directed scenarios pin it with literal values.
module tb_reg_ctx_sequencer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          Clk;
  logic          Reset_n;
  logic          WB_RegWrite;
  logic [4:0]    WB_WriteRegister;
  logic [DW-1:0] WB_WriteData;
  logic          LinkWrite;
  logic [DW-1:0] LinkData;
  logic [8*DW-1:0] tRegistersIn;
  logic          CtxSave;
  logic          CtxRestore;
  logic          CtxReady;
  logic          CtxErr;
  logic [2:0]    CtxDepth;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [DW-1:0] WriteData;

  reg_ctx_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .WB_RegWrite      (WB_RegWrite),
    .WB_WriteRegister (WB_WriteRegister),
    .WB_WriteData     (WB_WriteData),
    .LinkWrite        (LinkWrite),
    .LinkData         (LinkData),
    .tRegistersIn     (tRegistersIn),
    .CtxSave          (CtxSave),
    .CtxRestore       (CtxRestore),
    .CtxReady         (CtxReady),
    .CtxErr           (CtxErr),
    .CtxDepth         (CtxDepth),
    .RegWrite         (RegWrite),
    .WriteRegister    (WriteRegister),
    .WriteData        (WriteData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            c;
    logic [4:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic [8*DW-1:0] m_stack[$];
  bit              m_rest = 1'b0;
  int              m_idx = 0;
  bit              m_link_v = 1'b0;
  logic [DW-1:0]   m_link = '0;
  bit              m_err = 1'b0;
  wr_t             wlog[$];

  always @(negedge Clk) begin : model_cmp
    logic            e_we;
    logic [4:0]      e_a;
    logic [DW-1:0]   e_d;
    logic [8*DW-1:0] top;
    bit              r_issue;
    if (!Reset_n) begin
      m_stack.delete();
      m_rest   = 1'b0;
      m_idx    = 0;
      m_link_v = 1'b0;
      m_err    = 1'b0;
      chk("rst_ready", 64'(CtxReady), 64'd1);
      chk("rst_depth", 64'(CtxDepth), 64'd0);
      chk("rst_err",   64'(CtxErr),   64'd0);
      chk("rst_we",    64'(RegWrite), 64'd0);
      chk("rst_addr",  64'(WriteRegister), 64'd0);
      chk("rst_data",  64'(WriteData), 64'd0);
    end else begin
      e_we = 1'b0; e_a = 5'd0; e_d = '0; r_issue = 1'b0;
      if (WB_RegWrite) begin
        e_we = 1'b1; e_a = WB_WriteRegister; e_d = WB_WriteData;
      end else if (m_link_v || LinkWrite) begin
        e_we = 1'b1; e_a = 5'd31; e_d = LinkWrite ? LinkData : m_link;
      end else if (m_rest) begin
        top  = m_stack[m_stack.size()-1];
        e_we = 1'b1; e_a = 5'(8 + m_idx); e_d = top[(7-m_idx)*DW +: DW];
        r_issue = 1'b1;
      end
      chk("m_we",    64'(RegWrite), 64'(e_we));
      chk("m_addr",  64'(WriteRegister), 64'(e_a));
      chk("m_data",  64'(WriteData), 64'(e_d));
      chk("m_ready", 64'(CtxReady), 64'(!m_rest));
      chk("m_depth", 64'(CtxDepth), 64'(m_stack.size()));
      chk("m_err",   64'(CtxErr), 64'(m_err));
      // next state, as seen by the coming rising edge
      if (WB_RegWrite) begin
        if (LinkWrite) begin m_link_v = 1'b1; m_link = LinkData; end
      end else begin
        m_link_v = 1'b0;
      end
      m_err = 1'b0;
      if (!m_rest) begin
        if (CtxSave && CtxRestore) m_err = 1'b1;
        else if (CtxSave) begin
          if (m_stack.size() == DEPTH) m_err = 1'b1;
          else m_stack.push_back(tRegistersIn);
        end else if (CtxRestore) begin
          if (m_stack.size() == 0) m_err = 1'b1;
          else begin m_rest = 1'b1; m_idx = 0; end
        end
      end else if (r_issue) begin
        m_idx++;
        if (m_idx == 8) begin
          m_stack.pop_back();
          m_rest = 1'b0;
          m_idx  = 0;
        end
      end
    end
    if (RegWrite) wlog.push_back('{cyc, WriteRegister, WriteData});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_t(input logic [DW-1:0] step);
    for (int k = 0; k < 8; k++) tRegistersIn[(7-k)*DW +: DW] = step * DW'(k + 1);
  endtask

  task automatic pulse_save();
    CtxSave = 1'b1; tick(); CtxSave = 1'b0;
  endtask

  task automatic pulse_restore();
    CtxRestore = 1'b1; tick(); CtxRestore = 1'b0;
  endtask

  int n31;

  initial begin
    Reset_n = 1'b0; WB_RegWrite = 1'b0; WB_WriteRegister = 5'd0; WB_WriteData = '0;
    LinkWrite = 1'b0; LinkData = '0; tRegistersIn = '0; CtxSave = 1'b0; CtxRestore = 1'b0;
    repeat (3) tick();
    @(negedge Clk);
    chk("reset_ready", 64'(CtxReady), 64'd1);
    chk("reset_depth", 64'(CtxDepth), 64'd0);
    chk("reset_we",    64'(RegWrite), 64'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Round trip
    set_t(32'h11);
    pulse_save();
    chk("rt_depth_after_save", 64'(CtxDepth), 64'd1);
    set_t(32'h0);
    wlog.delete();
    pulse_restore();
    repeat (10) tick();
    chk("rt_nwrites", 64'(wlog.size()), 64'd8);
    if (wlog.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("rt_addr", 64'(wlog[k].a), 64'(8 + k));
        chk("rt_data", 64'(wlog[k].d), 64'(32'h11 * (k + 1)));
        chk("rt_cycle", 64'(wlog[k].c - wlog[0].c), 64'(k));
      end
    end
    chk("rt_depth_end", 64'(CtxDepth), 64'd0);
    chk("rt_ready_end", 64'(CtxReady), 64'd1);

    // Contention
    set_t(32'h11);
    pulse_save();
    set_t(32'h0);
    wlog.delete();
    CtxRestore = 1'b1; tick(); CtxRestore = 1'b0;
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd2; WB_WriteData = 32'hA5;
    LinkWrite = 1'b1; LinkData = 32'h400;
    tick();
    LinkWrite = 1'b0;
    repeat (2) tick();
    WB_RegWrite = 1'b0;
    repeat (12) tick();
    chk("ct_nwrites", 64'(wlog.size()), 64'd12);
    if (wlog.size() == 12) begin
      for (int k = 0; k < 3; k++) begin
        chk("ct_wb_addr", 64'(wlog[k].a), 64'd2);
        chk("ct_wb_data", 64'(wlog[k].d), 64'hA5);
      end
      chk("ct_link_addr", 64'(wlog[3].a), 64'd31);
      chk("ct_link_data", 64'(wlog[3].d), 64'h400);
      for (int k = 0; k < 8; k++) begin
        chk("ct_rs_addr", 64'(wlog[4+k].a), 64'(8 + k));
        chk("ct_rs_data", 64'(wlog[4+k].d), 64'(32'h11 * (k + 1)));
      end
      chk("ct_span", 64'(wlog[11].c - wlog[0].c + 1), 64'd12);
    end
    chk("ct_ready", 64'(CtxReady), 64'd1);

    // Link overwrite
    wlog.delete();
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd3; WB_WriteData = 32'h55;
    LinkWrite = 1'b1; LinkData = 32'h100;
    tick();
    LinkData = 32'h200;
    tick();
    LinkWrite = 1'b0;
    tick();
    WB_RegWrite = 1'b0;
    repeat (3) tick();
    n31 = 0;
    foreach (wlog[i]) if (wlog[i].a == 5'd31) n31++;
    chk("lo_n_r31", 64'(n31), 64'd1);
    chk("lo_nwrites", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) chk("lo_value", 64'(wlog[3].d), 64'h200);

    // Illegal: restore when empty
    pulse_restore();
    @(negedge Clk);
    chk("il_empty_err", 64'(CtxErr), 64'd1);
    tick();
    @(negedge Clk);
    chk("il_empty_err_clr", 64'(CtxErr), 64'd0);
    chk("il_empty_depth", 64'(CtxDepth), 64'd0);

    // Illegal: DEPTH+1 saves
    for (int i = 1; i <= DEPTH + 1; i++) begin
      set_t(DW'(i) << 12);
      pulse_save();
    end
    @(negedge Clk);
    chk("il_full_err", 64'(CtxErr), 64'd1);
    chk("il_full_depth", 64'(CtxDepth), 64'(DEPTH));
    tick();

    // Illegal: save and restore together
    CtxSave = 1'b1; CtxRestore = 1'b1;
    tick();
    CtxSave = 1'b0; CtxRestore = 1'b0;
    @(negedge Clk);
    chk("il_both_err", 64'(CtxErr), 64'd1);
    chk("il_both_depth", 64'(CtxDepth), 64'(DEPTH));
    tick();

    // Restore top context: it must be the 4th save (step 0x4000)
    wlog.delete();
    pulse_restore();
    repeat (10) tick();
    chk("lifo_nwrites", 64'(wlog.size()), 64'd8);
    if (wlog.size() == 8) chk("lifo_r8", 64'(wlog[0].d), 64'h4000);
    chk("lifo_depth", 64'(CtxDepth), 64'd3);

    // Reset mid-restore
    wlog.delete();
    pulse_restore();
    repeat (3) tick();
    Reset_n = 1'b0;
    #1;
    chk("mr_we", 64'(RegWrite), 64'd0);
    chk("mr_depth", 64'(CtxDepth), 64'd0);
    chk("mr_ready", 64'(CtxReady), 64'd1);
    tick();
    Reset_n = 1'b1;
    repeat (12) tick();
    chk("mr_nwrites", 64'(wlog.size()), 64'd3);
    chk("mr_depth_after", 64'(CtxDepth), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
